// File: rtl/pla_search_pkg.sv
// Shared definitions for the PLA preimage search block.
//   NX / NZ / CW : PLA input width, PLA output width, match-count width
//   state_t      : search FSM states (IDLE, SCAN, DONE)
//   masked_match : true when every care bit of a PLA output equals the target
package pla_search_pkg;

    localparam int NX = 9;
    localparam int NZ = 14;
    localparam int CW = NX + 1;  // must hold 0..2^NX inclusive

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic masked_match(input logic [NZ-1:0] z,
                                          input logic [NZ-1:0] target,
                                          input logic [NZ-1:0] mask);
        return ((z ^ target) & mask) == '0;
    endfunction

endpackage

// File: rtl/pla_preimage_search_if.sv
// Request/response bundle of the PLA preimage search block.
//   req_valid/req_ready/req_target/req_mask : search request
//   rsp_valid/rsp_ready/rsp_found/rsp_x/rsp_count : search result
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The requester holds req_target/req_mask while req_valid is high;
// the block holds every rsp_* field stable while rsp_valid is high and
// rsp_ready is low. A valid never waits on ready to rise.
// Modports: master = requester/consumer, slave = the search block.
interface pla_preimage_search_if;
    import pla_search_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [NZ-1:0] req_target;
    logic [NZ-1:0] req_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_found;
    logic [NX-1:0] rsp_x;
    logic [CW-1:0] rsp_count;

    modport master (
        output req_valid, req_target, req_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_found, rsp_x, rsp_count
    );

    modport slave (
        input  req_valid, req_target, req_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_found, rsp_x, rsp_count
    );

endinterface

// File: rtl/pla_masked_match.sv
// Combinational NZ-wide masked equality between a PLA response and a target.
//   z      : PLA output under test
//   target : desired pattern
//   mask   : care bits (1 = compare)
//   match  : high when all care bits agree
module pla_masked_match
    import pla_search_pkg::*;
(
    input  logic [NZ-1:0] z,
    input  logic [NZ-1:0] target,
    input  logic [NZ-1:0] mask,
    output logic          match
);

    assign match = masked_match(z, target, mask);

endmodule

// File: rtl/pla_preimage_search.sv
// Sweeps all 2^NX input vectors through an external combinational PLA and
// reports the lowest vector whose outputs match a masked target.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response bundle (slave side)
//   probe_x   : vector driven to the external PLA
//   probe_z   : PLA response to probe_x, same cycle
//   busy      : high while scanning
//   state_dbg : current FSM state
// Build option: PLA_PREIMAGE_COUNT_EN enables a full sweep with an exact
// match count; without it the scan stops on the first match and rsp_count
// reads 0.
module pla_preimage_search
    import pla_search_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pla_preimage_search_if.slave  bus,
    output logic [NX-1:0]         probe_x,
    input  logic [NZ-1:0]         probe_z,
    output logic                  busy,
    output state_t                state_dbg
);

`ifdef PLA_PREIMAGE_COUNT_EN
    localparam bit EARLY_EXIT = 1'b0;
    logic [CW-1:0] count_q;
`else
    localparam bit EARLY_EXIT = 1'b1;
`endif

    state_t        state_q, state_d;
    logic [NZ-1:0] target_q;
    logic [NZ-1:0] mask_q;
    logic          found_q;
    logic [NX-1:0] rsp_x_q;
    logic          match;
    logic          scan_end;
    logic          accept;

    pla_masked_match u_match (
        .z      (probe_z),
        .target (target_q),
        .mask   (mask_q),
        .match  (match)
    );

    assign accept   = (state_q == IDLE) && bus.req_valid;
    // Last vector always ends the sweep; a hit ends it early when not counting.
    assign scan_end = (probe_x == '1) || (EARLY_EXIT && match);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = SCAN;
            SCAN:    if (scan_end)      state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            mask_q   <= '0;
            probe_x  <= '0;
            found_q  <= 1'b0;
            rsp_x_q  <= '0;
`ifdef PLA_PREIMAGE_COUNT_EN
            count_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                target_q <= bus.req_target;
                mask_q   <= bus.req_mask;
                probe_x  <= '0;
                found_q  <= 1'b0;
                rsp_x_q  <= '0;
`ifdef PLA_PREIMAGE_COUNT_EN
                count_q  <= '0;
`endif
            end else if (state_q == SCAN) begin
                if (match && !found_q) begin
                    found_q <= 1'b1;
                    rsp_x_q <= probe_x;
                end
`ifdef PLA_PREIMAGE_COUNT_EN
                if (match) count_q <= count_q + CW'(1);
`endif
                // probe_x stays on the final vector once the scan ends.
                if (!scan_end) probe_x <= probe_x + NX'(1);
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_found = found_q;
    assign bus.rsp_x     = rsp_x_q;
`ifdef PLA_PREIMAGE_COUNT_EN
    assign bus.rsp_count = count_q;
`else
    assign bus.rsp_count = '0;
`endif
    assign busy      = (state_q == SCAN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pla_preimage_search.sv
// Self-checking bench for pla_preimage_search: a stub PLA (or a small
// production-style PLA) is wired to probe_x/probe_z, and a sweep model over
// all input vectors predicts found/first/count and latency per request.
module tb_pla_preimage_search;
    import pla_search_pkg::*;

`ifdef PLA_PREIMAGE_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif
    localparam int EW = 1 + NX + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NX-1:0] probe_x;
    logic [NZ-1:0] probe_z;
    logic          busy;
    state_t        state_dbg;
    bit            use_prod = 1'b0;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    pla_preimage_search_if bus();

    pla_preimage_search dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .probe_x   (probe_x),
        .probe_z   (probe_z),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Stub PLA passes the vector through; the production-style PLA mixes
    // product/sum terms in the upper bits and inverts bit 3 in the low bits.
    function automatic logic [NZ-1:0] pla_f(input logic [NX-1:0] x, input bit prod);
        if (!prod) return {5'b0, x};
        return {x[0] & x[1], x[2] | x[3], x[4] ^ x[5], x[6] & ~x[7], x[8], x ^ 9'h008};
    endfunction

    always_comb probe_z = pla_f(probe_x, use_prod);

    // ---------------- reference model ----------------
    function automatic void model(input logic [NZ-1:0] t, input logic [NZ-1:0] m,
                                  output bit f, output int first, output int cnt);
        f = 1'b0; first = 0; cnt = 0;
        for (int x = 0; x < (1 << NX); x++) begin
            logic [NZ-1:0] z;
            bit ok;
            z  = pla_f(x[NX-1:0], use_prod);
            ok = 1'b1;
            for (int i = 0; i < NZ; i++)
                if (m[i] && (z[i] != t[i])) ok = 1'b0;
            if (ok) begin
                if (!f) begin f = 1'b1; first = x; end
                cnt++;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_found", bus.rsp_found, exp_q[0][EW-1]);
                check("rsp_x",     bus.rsp_x,     exp_q[0][NX+CW-1:CW]);
                check("rsp_count", bus.rsp_count, exp_q[0][CW-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic accept(input logic [NZ-1:0] t, input logic [NZ-1:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_target = t;
        bus.req_mask   = m;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [NZ-1:0] t, input logic [NZ-1:0] m, input int hold);
        bit            f;
        int            first, cnt, lat, exp_lat, exp_px;
        logic [NX-1:0] ex;
        logic [CW-1:0] ec;
        model(t, m, f, first, cnt);
        ex = f ? first[NX-1:0] : '0;
        ec = CNT ? cnt[CW-1:0] : '0;
        exp_q.push_back({f, ex, ec});
        accept(t, m);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.rsp_valid) break;
            if (lat > 600) begin
                check("rsp_timeout", 32'd0, 32'd1);
                break;
            end
        end
        exp_lat = CNT ? 512 : (f ? first + 1 : 512);
        check("latency", lat, exp_lat);
        exp_px = (CNT || !f) ? 511 : first;
        check("probe_x_held", probe_x, exp_px);
        check("busy_done", busy, 0);
        repeat (hold) begin
            @(negedge clk);
            check("req_ready_in_done", bus.req_ready, 0);
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_target = 14'($urandom);
            bus.req_mask   = 14'($urandom);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
        check("post_busy",      busy,          0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit f;
        int first, cnt;
        bus.req_valid  = 1'b0;
        bus.req_target = '0;
        bus.req_mask   = '0;
        bus.rsp_ready  = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy",      busy,          0);
        check("rst_found",     bus.rsp_found, 0);
        check("rst_x",         bus.rsp_x,     0);
        check("rst_count",     bus.rsp_count, 0);
        check("rst_probe_x",   probe_x,       0);
        check("rst_state",     state_dbg,     IDLE);
        rst = 1'b0;

        // Pin the model against hand-computed values.
        model(14'h0005, 14'h3FFF, f, first, cnt);
        check("model_5_found", f, 1); check("model_5_first", first, 5); check("model_5_cnt", cnt, 1);
        model(14'h0001, 14'h0001, f, first, cnt);
        check("model_1_first", first, 1); check("model_1_cnt", cnt, 256);
        model(14'h0000, 14'h0000, f, first, cnt);
        check("model_m0_first", first, 0); check("model_m0_cnt", cnt, 512);
        model(14'h0200, 14'h3FFF, f, first, cnt);
        check("model_200_found", f, 0); check("model_200_cnt", cnt, 0);

        // Directed cases.
        run_req(14'h0005, 14'h3FFF, 0);
        run_req(14'h0200, 14'h3FFF, 0);
        run_req(14'h0000, 14'h0000, 0);
        run_req(14'h0001, 14'h0001, 10);

        // Randomized requests.
        repeat (8) begin
            logic [NZ-1:0] t, m;
            t = {5'b0, 9'($urandom_range(0, 511))};
            if ($urandom_range(0, 3) == 0) t[NZ-1:NX] = 5'($urandom);
            m = ($urandom_range(0, 2) == 0) ? 14'h3FFF : 14'($urandom);
            run_req(t, m, $urandom_range(0, 3));
        end

        // Reset in the middle of a scan discards the request.
        accept(14'h0200, 14'h3FFF);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_busy",      busy,          0);
        check("midrst_req_ready", bus.req_ready, 1);
        check("midrst_found",     bus.rsp_found, 0);
        check("midrst_x",         bus.rsp_x,     0);
        check("midrst_count",     bus.rsp_count, 0);
        check("midrst_probe_x",   probe_x,       0);
        run_req(14'h0003, 14'h3FFF, 0);

        // Production-style PLA wired on.
        use_prod = 1'b1;
        model(14'h0008, 14'h3FFF, f, first, cnt);
        check("model_prod_found", f, 1); check("model_prod_first", first, 0);
        run_req(14'h0008, 14'h3FFF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
